// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM state encodings shared by alu_seq and its mul/div engine
package alu_pkg;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHRA = 5'h08;
    localparam logic [4:0] OP_SHL  = 5'h09;
    localparam logic [4:0] OP_ROR  = 5'h0A;
    localparam logic [4:0] OP_ROL  = 5'h0B;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_ANDI = 5'h0D;
    localparam logic [4:0] OP_ORI  = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_NEG  = 5'h11;
    localparam logic [4:0] OP_NOT  = 5'h12;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} alu_state_t;
endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative signed mul/div engine on operand magnitudes, sign applied in S_FIX
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go_mul,
    input  logic             go_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    alu_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic is_div, neg_q, neg_r, ge;
    logic [WIDTH-1:0] b_mag, p_hi, p_lo, diff;
    logic [WIDTH:0] sum, shifted;

    always_ff @(posedge clock)
        state <= reset ? S_IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       state_nx = go_mul ? S_MUL : go_div ? S_DIV : S_IDLE;
            S_MUL, S_DIV: state_nx = cnt == '0 ? S_FIX : state;
            default:      state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = state != S_IDLE;
        fin  = state == S_FIX;
    end

    // mul: {p_hi,p_lo} shifts right, multiplier drains out of p_lo; div: p_hi is the partial remainder
    assign sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_mag} : '0);
    assign shifted = {p_hi, p_lo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, b_mag};
    assign diff    = WIDTH'(shifted - {1'b0, b_mag});

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_mag  <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else if (go_mul || go_div) begin
            cnt    <= CW'(WIDTH - 1);
            is_div <= go_div;
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            b_mag  <= b[WIDTH-1] ? -b : b;
            p_hi   <= '0;
            p_lo   <= a[WIDTH-1] ? -a : a;
        end else if (state == S_MUL) begin
            cnt    <= cnt - CW'(1);
            p_hi   <= sum[WIDTH:1];
            p_lo   <= {sum[0], p_lo[WIDTH-1:1]};
        end else if (state == S_DIV) begin
            cnt    <= cnt - CW'(1);
            p_hi   <= ge ? diff : shifted[WIDTH-1:0];
            p_lo   <= {p_lo[WIDTH-2:0], ge};
        end
    end

    assign {hi, lo} = is_div ? {neg_r ? -p_hi : p_hi, neg_q ? -p_lo : p_lo}
                             : neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake and registered Z_high/Z_low.
// ALU_SEQ_DIVZ_EN adds a divz output and a one-cycle divide-by-zero path.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       instruction,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z_high,
    output logic [WIDTH-1:0] Z_low
`ifdef ALU_SEQ_DIVZ_EN
    ,
    output logic             divz
`endif
);
    localparam int SHW = $clog2(WIDTH);

    logic accept, is_mul, is_div, dz, go_mul, go_div, go_one, fin;
    logic [SHW-1:0] sh;
    logic [WIDTH-1:0] res, one_hi, one_lo, eng_hi, eng_lo;

    assign sh     = B_in[SHW-1:0];
    assign accept = start && !busy;
    assign is_mul = instruction == OP_MUL;
    assign is_div = instruction == OP_DIV;
`ifdef ALU_SEQ_DIVZ_EN
    assign dz     = is_div && B_in == '0;
`else
    assign dz     = 1'b0;
`endif
    assign go_mul = accept && is_mul;
    assign go_div = accept && is_div && !dz;
    assign go_one = accept && !go_mul && !go_div;
    assign one_hi = dz ? A_in : '0;
    assign one_lo = dz ? '1 : res;

    // rotates read a window of the doubled operand; rol by n equals ror by WIDTH-n
    always_comb begin
        case (instruction)
            OP_ADD, OP_ADDI: res = A_in + B_in;
            OP_SUB:          res = A_in - B_in;
            OP_AND, OP_ANDI: res = A_in & B_in;
            OP_OR, OP_ORI:   res = A_in | B_in;
            OP_SHR:          res = A_in >> sh;
            OP_SHRA:         res = $signed(A_in) >>> sh;
            OP_SHL:          res = A_in << sh;
            OP_ROR:          res = WIDTH'({A_in, A_in} >> sh);
            OP_ROL:          res = WIDTH'({A_in, A_in} >> (WIDTH - int'(sh)));
            OP_NEG:          res = -B_in;
            OP_NOT:          res = ~B_in;
            default:         res = '0;
        endcase
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .go_mul (go_mul),
        .go_div (go_div),
        .a      (A_in),
        .b      (B_in),
        .busy   (busy),
        .fin    (fin),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            done   <= 1'b0;
            Z_high <= '0;
            Z_low  <= '0;
        end else begin
            done <= go_one || fin;
            if (go_one || fin)
                {Z_high, Z_low} <= go_one ? {one_hi, one_lo} : {eng_hi, eng_lo};
        end
    end

`ifdef ALU_SEQ_DIVZ_EN
    always_ff @(posedge clock)
        divz <= !reset && go_one && dz;
`endif
endmodule
